// File: rtl/commit_dests.sv
// Write-back stage: retires dest0 then dest1 of a decoded step into the GPR file,
// and checks memory destinations against the step's write hints.
module commit_dests #(
    parameter logic [31:0] RESET_ESP          = 32'h0000_0000,
    parameter bit          CHECK_UNUSED_HINTS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  dest0_kind,
    input  logic [31:0] dest0_sel,
    input  logic [31:0] dest0_val,
    input  logic [1:0]  dest1_kind,
    input  logic [31:0] dest1_sel,
    input  logic [31:0] dest1_val,
    input  logic        reg_1byte,
    input  logic        prefix_operand_16bit,
    input  logic        hint1_is_write,
    input  logic [31:0] hint1_address,
    input  logic [31:0] hint1_data,
    input  logic        hint2_is_write,
    input  logic [31:0] hint2_address,
    input  logic [31:0] hint2_data,
    output logic [31:0] eax,
    output logic [31:0] ecx,
    output logic [31:0] edx,
    output logic [31:0] ebx,
    output logic [31:0] esp,
    output logic [31:0] ebp,
    output logic [31:0] esi,
    output logic [31:0] edi,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code
);

    typedef enum logic [1:0] {IDLE, D0, D1, FIN} state_t;

    localparam logic [1:0] K_REG = 2'b01;
    localparam logic [1:0] K_MEM = 2'b10;
    localparam logic [1:0] K_BAD = 2'b11;

    state_t state, next_state;

    logic [7:0][31:0] gpr;

    logic [1:0]  k0_q, k1_q;
    logic [31:0] s0_q, s1_q, v0_q, v1_q;
    logic        byte_q, w16_q;
    logic        h1_w_q, h2_w_q, h1_used, h2_used;
    logic [31:0] h1_a_q, h1_d_q, h2_a_q, h2_d_q;

    logic [1:0]  cur_kind;
    logic [31:0] cur_sel, cur_val, mask, old_val, wr_data;
    logic [2:0]  wr_idx;
    logic        reg_we, h1_take, h2_take, m1, m2, ev_err;
    logic [2:0]  ev_code;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = D0;
            D0:      next_state = D1;
            D1:      next_state = FIN;
            default: next_state = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign done     = (state == FIN);

    always_comb begin
        cur_kind = (state == D1) ? k1_q : k0_q;
        cur_sel  = (state == D1) ? s1_q : s0_q;
        cur_val  = (state == D1) ? v1_q : v0_q;
        mask     = byte_q ? 32'h0000_00FF : (w16_q ? 32'h0000_FFFF : 32'hFFFF_FFFF);

        // In byte mode selectors 4-7 name AH/CH/DH/BH, i.e. bits [15:8] of regs 0-3.
        wr_idx  = (byte_q && cur_sel[2]) ? {1'b0, cur_sel[1:0]} : cur_sel[2:0];
        old_val = gpr[wr_idx];
        if (byte_q && cur_sel[2])
            wr_data = {old_val[31:16], cur_val[7:0], old_val[7:0]};
        else if (byte_q)
            wr_data = {old_val[31:8], cur_val[7:0]};
        else if (w16_q)
            wr_data = {old_val[31:16], cur_val[15:0]};
        else
            wr_data = cur_val;

        m1 = h1_w_q && !h1_used && (h1_a_q == cur_sel);
        m2 = h2_w_q && !h2_used && (h2_a_q == cur_sel);

        reg_we  = 1'b0;
        h1_take = 1'b0;
        h2_take = 1'b0;
        ev_err  = 1'b0;
        ev_code = 3'd0;

        if (state == D0 || state == D1) begin
            case (cur_kind)
                K_REG: reg_we = 1'b1;
                K_MEM: begin
                    if (m1) begin
                        h1_take = 1'b1;
                        if ((h1_d_q & mask) != (cur_val & mask)) begin
                            ev_err  = 1'b1;
                            ev_code = 3'd3;
                        end
                    end else if (m2) begin
                        h2_take = 1'b1;
                        if ((h2_d_q & mask) != (cur_val & mask)) begin
                            ev_err  = 1'b1;
                            ev_code = 3'd3;
                        end
                    end else begin
                        ev_err  = 1'b1;
                        ev_code = 3'd2;
                    end
                end
                K_BAD: begin
                    ev_err  = 1'b1;
                    ev_code = 3'd1;
                end
                default: ;
            endcase
        end else if (state == FIN && CHECK_UNUSED_HINTS &&
                     ((h1_w_q && !h1_used) || (h2_w_q && !h2_used))) begin
            ev_err  = 1'b1;
            ev_code = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gpr      <= '0;
            gpr[4]   <= RESET_ESP;
            err      <= 1'b0;
            err_code <= 3'd0;
            k0_q     <= '0;
            k1_q     <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            v0_q     <= '0;
            v1_q     <= '0;
            byte_q   <= 1'b0;
            w16_q    <= 1'b0;
            h1_w_q   <= 1'b0;
            h2_w_q   <= 1'b0;
            h1_a_q   <= '0;
            h1_d_q   <= '0;
            h2_a_q   <= '0;
            h2_d_q   <= '0;
            h1_used  <= 1'b0;
            h2_used  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && in_valid) begin
                k0_q    <= dest0_kind;
                s0_q    <= dest0_sel;
                v0_q    <= dest0_val;
                k1_q    <= dest1_kind;
                s1_q    <= dest1_sel;
                v1_q    <= dest1_val;
                byte_q  <= reg_1byte;
                w16_q   <= prefix_operand_16bit;
                h1_w_q  <= hint1_is_write;
                h1_a_q  <= hint1_address;
                h1_d_q  <= hint1_data;
                h2_w_q  <= hint2_is_write;
                h2_a_q  <= hint2_address;
                h2_d_q  <= hint2_data;
                h1_used <= 1'b0;
                h2_used <= 1'b0;
            end
            if (reg_we)  gpr[wr_idx] <= wr_data;
            if (h1_take) h1_used <= 1'b1;
            if (h2_take) h2_used <= 1'b1;
            // Only the first error is recorded; err stays up until reset.
            if (ev_err && !err) begin
                err      <= 1'b1;
                err_code <= ev_code;
            end
        end
    end

    assign eax = gpr[0];
    assign ecx = gpr[1];
    assign edx = gpr[2];
    assign ebx = gpr[3];
    assign esp = gpr[4];
    assign ebp = gpr[5];
    assign esi = gpr[6];
    assign edi = gpr[7];

endmodule

// File: tb/tb_commit_dests.sv
// Directed bench for commit_dests: two instances differing only in CHECK_UNUSED_HINTS.
module tb_commit_dests;

    localparam logic [31:0] RST_ESP = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  dest0_kind, dest1_kind;
    logic [31:0] dest0_sel, dest0_val, dest1_sel, dest1_val;
    logic        reg_1byte, prefix_operand_16bit;
    logic        hint1_is_write, hint2_is_write;
    logic [31:0] hint1_address, hint1_data, hint2_address, hint2_data;

    logic        in_ready, done, err;
    logic [2:0]  err_code;
    logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;

    logic        in_ready_n, done_n, err_n;
    logic [2:0]  err_code_n;
    logic [31:0] eax_n, ecx_n, edx_n, ebx_n, esp_n, ebp_n, esi_n, edi_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    commit_dests #(.RESET_ESP(RST_ESP), .CHECK_UNUSED_HINTS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dest0_kind(dest0_kind), .dest0_sel(dest0_sel), .dest0_val(dest0_val),
        .dest1_kind(dest1_kind), .dest1_sel(dest1_sel), .dest1_val(dest1_val),
        .reg_1byte(reg_1byte), .prefix_operand_16bit(prefix_operand_16bit),
        .hint1_is_write(hint1_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
        .hint2_is_write(hint2_is_write), .hint2_address(hint2_address), .hint2_data(hint2_data),
        .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
        .done(done), .err(err), .err_code(err_code)
    );

    commit_dests #(.RESET_ESP(RST_ESP), .CHECK_UNUSED_HINTS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .dest0_kind(dest0_kind), .dest0_sel(dest0_sel), .dest0_val(dest0_val),
        .dest1_kind(dest1_kind), .dest1_sel(dest1_sel), .dest1_val(dest1_val),
        .reg_1byte(reg_1byte), .prefix_operand_16bit(prefix_operand_16bit),
        .hint1_is_write(hint1_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
        .hint2_is_write(hint2_is_write), .hint2_address(hint2_address), .hint2_data(hint2_data),
        .eax(eax_n), .ecx(ecx_n), .edx(edx_n), .ebx(ebx_n), .esp(esp_n), .ebp(ebp_n),
        .esi(esi_n), .edi(edi_n),
        .done(done_n), .err(err_n), .err_code(err_code_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 1'b0;
        dest0_kind = 2'b00; dest0_sel = '0; dest0_val = '0;
        dest1_kind = 2'b00; dest1_sel = '0; dest1_val = '0;
        reg_1byte = 1'b0; prefix_operand_16bit = 1'b0;
        hint1_is_write = 1'b0; hint1_address = '0; hint1_data = '0;
        hint2_is_write = 1'b0; hint2_address = '0; hint2_data = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Request inputs must be set beforehand; walks the request back to IDLE.
    task automatic run(input string tag);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, " busy"}, 32'(in_ready), 32'd0);
        step();
        step();
        chk({tag, " done"}, 32'(done), 32'd1);
        step();
        chk({tag, " idle"}, 32'(in_ready), 32'd1);
        clr();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        step();
        chk("rst eax", eax, 32'd0);
        chk("rst esp", esp, RST_ESP);
        chk("rst edi", edi, 32'd0);
        chk("rst ready", 32'(in_ready), 32'd1);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst code", 32'(err_code), 32'd0);
        rst = 1'b0;

        // 32-bit REG write, with explicit latency check
        dest0_kind = 2'b01; dest0_sel = 32'd3; dest0_val = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1 ready D0", 32'(in_ready), 32'd0);
        chk("t1 done D0", 32'(done), 32'd0);
        step();
        chk("t1 ebx", ebx, 32'hDEAD_BEEF);
        chk("t1 done D1", 32'(done), 32'd0);
        step();
        chk("t1 done FIN", 32'(done), 32'd1);
        step();
        chk("t1 done after", 32'(done), 32'd0);
        chk("t1 err", 32'(err), 32'd0);
        chk("t1 esp", esp, RST_ESP);
        clr();

        // sub-register writes into EAX
        dest0_kind = 2'b01; dest0_sel = 32'd0; dest0_val = 32'h1122_3344;
        run("eax32");
        chk("eax32 val", eax, 32'h1122_3344);
        dest0_kind = 2'b01; dest0_sel = 32'd4; dest0_val = 32'h0000_00AB; reg_1byte = 1'b1;
        run("ah");
        chk("ah val", eax, 32'h1122_AB44);
        dest0_kind = 2'b01; dest0_sel = 32'd0; dest0_val = 32'hFFFF_5555; prefix_operand_16bit = 1'b1;
        run("ax");
        chk("ax val", eax, 32'h1122_5555);
        dest0_kind = 2'b01; dest0_sel = 32'd0; dest0_val = 32'hFFFF_FF77;
        reg_1byte = 1'b1; prefix_operand_16bit = 1'b1;
        run("al");
        chk("al val", eax, 32'h1122_5577);

        // same register twice: dest1 wins, dest0 visible for one cycle
        dest0_kind = 2'b01; dest0_sel = 32'd1; dest0_val = 32'd1;
        dest1_kind = 2'b01; dest1_sel = 32'd1; dest1_val = 32'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ecx before", ecx, 32'd0);
        step();
        chk("ecx after D0", ecx, 32'd1);
        step();
        chk("ecx after D1", ecx, 32'd2);
        step();
        chk("ecx final", ecx, 32'd2);
        clr();

        // MEM dest matched by the second hint, the first hint is a read
        dest0_kind = 2'b10; dest0_sel = 32'h1000; dest0_val = 32'h55;
        hint1_is_write = 1'b0; hint1_address = 32'h1000; hint1_data = 32'h99;
        hint2_is_write = 1'b1; hint2_address = 32'h1000; hint2_data = 32'h55;
        run("mem ok");
        chk("mem ok err", 32'(err), 32'd0);

        // byte-width compare ignores upper bits
        dest0_kind = 2'b10; dest0_sel = 32'h2000; dest0_val = 32'hFFFF_FF55; reg_1byte = 1'b1;
        hint1_is_write = 1'b1; hint1_address = 32'h2000; hint1_data = 32'h0000_0055;
        run("mem byte");
        chk("mem byte err", 32'(err), 32'd0);

        // two MEM dests consume both hints in order
        dest0_kind = 2'b10; dest0_sel = 32'h3000; dest0_val = 32'h11;
        dest1_kind = 2'b10; dest1_sel = 32'h3000; dest1_val = 32'h22;
        hint1_is_write = 1'b1; hint1_address = 32'h3000; hint1_data = 32'h11;
        hint2_is_write = 1'b1; hint2_address = 32'h3000; hint2_data = 32'h22;
        run("mem two");
        chk("mem two err", 32'(err), 32'd0);

        // data mismatch
        dest0_kind = 2'b10; dest0_sel = 32'h1000; dest0_val = 32'h56;
        hint2_is_write = 1'b1; hint2_address = 32'h1000; hint2_data = 32'h55;
        run("mem bad");
        chk("mem bad err", 32'(err), 32'd1);
        chk("mem bad code", 32'(err_code), 32'd3);

        // no hint at that address; first error code sticks over the later unused-hint error
        do_reset();
        chk("nohint pre", 32'(err), 32'd0);
        dest0_kind = 2'b10; dest0_sel = 32'h2000; dest0_val = 32'h1;
        hint1_is_write = 1'b1; hint1_address = 32'h1000; hint1_data = 32'h1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("nohint err D1", 32'(err), 32'd1);
        chk("nohint code", 32'(err_code), 32'd2);
        chk("nohint code p0", 32'(err_code_n), 32'd2);
        step();
        step();
        chk("nohint code end", 32'(err_code), 32'd2);
        clr();

        // unused write hint
        do_reset();
        hint1_is_write = 1'b1; hint1_address = 32'h1000; hint1_data = 32'h7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("unused err FIN", 32'(err), 32'd0);
        step();
        chk("unused err", 32'(err), 32'd1);
        chk("unused code", 32'(err_code), 32'd4);
        chk("unused p0 err", 32'(err_n), 32'd0);
        clr();

        // illegal kind on dest0, dest1 still retires
        do_reset();
        dest0_kind = 2'b11; dest0_sel = 32'd2; dest0_val = 32'hBAD0_BAD0;
        dest1_kind = 2'b01; dest1_sel = 32'd2; dest1_val = 32'h0000_1234;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("bad edx", edx, 32'd0);
        chk("bad code", 32'(err_code), 32'd1);
        step();
        chk("bad done", 32'(done), 32'd1);
        step();
        chk("bad edx final", edx, 32'h0000_1234);
        clr();

        // reset in D1 discards the request
        do_reset();
        dest0_kind = 2'b01; dest0_sel = 32'd6; dest0_val = 32'h0000_AAAA;
        dest1_kind = 2'b01; dest1_sel = 32'd5; dest1_val = 32'h0000_BBBB;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid esi", esi, 32'h0000_AAAA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid ready", 32'(in_ready), 32'd1);
        chk("mid esi rst", esi, 32'd0);
        chk("mid ebp", ebp, 32'd0);
        chk("mid esp", esp, RST_ESP);
        chk("mid done", 32'(done), 32'd0);
        step();
        chk("mid done2", 32'(done), 32'd0);
        clr();

        // in_valid held high while busy is not re-accepted
        dest0_kind = 2'b01; dest0_sel = 32'd7; dest0_val = 32'd1;
        in_valid = 1'b1;
        step();
        dest0_val = 32'd2;
        step();
        chk("hold edi D0", edi, 32'd1);
        chk("hold ready D1", 32'(in_ready), 32'd0);
        step();
        chk("hold ready FIN", 32'(in_ready), 32'd0);
        chk("hold done", 32'(done), 32'd1);
        step();
        chk("hold ready idle", 32'(in_ready), 32'd1);
        chk("hold edi idle", edi, 32'd1);
        step();
        in_valid = 1'b0;
        chk("hold reaccept", 32'(in_ready), 32'd0);
        step();
        chk("hold edi 2", edi, 32'd2);
        step();
        step();
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
